// File: rtl/float_adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : float_arb_pkg
// Purpose  : Shared types and constants for the shared float adder arbiter.
//            Holds the arbiter state encoding and IEEE-754 single-precision
//            field constants.
// Revision : 1.0 - initial release
// ============================================================================
package float_arb_pkg;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Z = 2'd2,
        RETURN = 2'd3
    } state_t;

endpackage : float_arb_pkg
`default_nettype wire

// File: rtl/float_adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : float_adder_arbiter_if
// Purpose  : Bundles the requester-side and adder-side handshakes of the
//            shared float adder arbiter.
// Ports    : REQ_STB/REQ_SUB/REQ_A/REQ_B/REQ_ACK - operand request channel
//            RES_Z/RES_STB/RES_ACK                - result return channel
//            ADD_A/ADD_B/ADD_AB_STB/ADD_AB_ACK    - adder operand handshake
//            ADD_Z/ADD_Z_STB/ADD_Z_ACK            - adder result handshake
//            slave  : arbiter view
//            master : requesters + adder view
// Revision : 1.0 - initial release
// ============================================================================
interface float_adder_arbiter_if #(
    parameter int N_REQ = 4
);
    import float_arb_pkg::*;

    logic [N_REQ-1:0]      REQ_STB;
    logic [N_REQ-1:0]      REQ_SUB;
    logic [FP_W*N_REQ-1:0] REQ_A;
    logic [FP_W*N_REQ-1:0] REQ_B;
    logic [N_REQ-1:0]      REQ_ACK;
    logic [FP_W-1:0]       RES_Z;
    logic [N_REQ-1:0]      RES_STB;
    logic [N_REQ-1:0]      RES_ACK;
    logic [FP_W-1:0]       ADD_A;
    logic [FP_W-1:0]       ADD_B;
    logic                  ADD_AB_STB;
    logic                  ADD_AB_ACK;
    logic [FP_W-1:0]       ADD_Z;
    logic                  ADD_Z_STB;
    logic                  ADD_Z_ACK;

    modport slave (
        input  REQ_STB, REQ_SUB, REQ_A, REQ_B, RES_ACK,
        input  ADD_AB_ACK, ADD_Z, ADD_Z_STB,
        output REQ_ACK, RES_Z, RES_STB,
        output ADD_A, ADD_B, ADD_AB_STB, ADD_Z_ACK
    );

    modport master (
        output REQ_STB, REQ_SUB, REQ_A, REQ_B, RES_ACK,
        output ADD_AB_ACK, ADD_Z, ADD_Z_STB,
        input  REQ_ACK, RES_Z, RES_STB,
        input  ADD_A, ADD_B, ADD_AB_STB, ADD_Z_ACK
    );

endinterface : float_adder_arbiter_if
`default_nettype wire

// File: rtl/float_adder_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority pick. Returns the first set
//            request bit at or above i_ptr, wrapping past N_REQ-1 to 0.
// Ports    : i_req   - request vector
//            i_ptr   - highest-priority index for this pick
//            o_valid - any request set
//            o_idx   - winning index (0 when o_valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic                  o_valid,
    output logic [IDX_W-1:0]      o_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_pos;

    // Scan offsets from the far end back toward the pointer so the candidate
    // nearest to i_ptr is the last one written and therefore wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_pos = {1'b0, i_ptr} + SUM_W'(i);
            if (w_pos >= SUM_W'(N_REQ)) begin
                w_pos = w_pos - SUM_W'(N_REQ);
            end
            if (i_req[w_pos[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/float_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_adder_arbiter
// Purpose  : Shares one non-pipelined IEEE-754 single adder among N_REQ
//            requesters with round-robin arbitration, one operation in
//            flight. Optional per-request subtract flips B's sign on issue.
//            Each result is returned only to the requester that issued it.
// Ports    : i_CLK  - clock
//            i_RSTN - asynchronous active-low reset
//            bus    - requester and adder handshakes (slave modport)
//            o_BUSY - high whenever the arbiter is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module float_adder_arbiter
    import float_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic            i_CLK,
    input  wire logic            i_RSTN,
    float_adder_arbiter_if.slave bus,
    output logic                 o_BUSY
);

    state_t            r_state,   w_state;
    logic [IDX_W-1:0]  r_rr_ptr,  w_rr_ptr;
    logic [IDX_W-1:0]  r_grant,   w_grant;
    logic [FP_W-1:0]   r_add_a,   w_add_a;
    logic [FP_W-1:0]   r_add_b,   w_add_b;
    logic              r_ab_stb,  w_ab_stb;
    logic              r_z_ack,   w_z_ack;
    logic [FP_W-1:0]   r_res_z,   w_res_z;
    logic [N_REQ-1:0]  r_res_stb, w_res_stb;
    logic [N_REQ-1:0]  r_req_ack, w_req_ack;
    logic              r_busy,    w_busy;

    logic              w_pick_vld;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [FP_W-1:0]   w_req_a [N_REQ];
    logic [FP_W-1:0]   w_req_b [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_req_a[k] = bus.REQ_A[FP_W*k +: FP_W];
        assign w_req_b[k] = bus.REQ_B[FP_W*k +: FP_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.REQ_STB),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state   = r_state;
        w_rr_ptr  = r_rr_ptr;
        w_grant   = r_grant;
        w_add_a   = r_add_a;
        w_add_b   = r_add_b;
        w_ab_stb  = r_ab_stb;
        w_z_ack   = 1'b0;
        w_res_z   = r_res_z;
        w_res_stb = r_res_stb;
        w_req_ack = '0;

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant   = w_pick_idx;
                    w_add_a   = w_req_a[w_pick_idx];
                    // Subtract is A + (-B): only the sign of B changes.
                    w_add_b   = {w_req_b[w_pick_idx][FP_SIGN_BIT] ^ bus.REQ_SUB[w_pick_idx],
                                 w_req_b[w_pick_idx][FP_SIGN_BIT-1:0]};
                    w_req_ack[w_pick_idx] = 1'b1;
                    w_ab_stb  = 1'b1;
                    w_state   = ISSUE;
                end
            end
            ISSUE: begin
                if (r_ab_stb && bus.ADD_AB_ACK) begin
                    w_ab_stb = 1'b0;
                    w_state  = WAIT_Z;
                end
            end
            WAIT_Z: begin
                // Leaving WAIT_Z on the capture keeps Z_ACK to a single cycle.
                if (bus.ADD_Z_STB) begin
                    w_res_z            = bus.ADD_Z;
                    w_z_ack            = 1'b1;
                    w_res_stb          = '0;
                    w_res_stb[r_grant] = 1'b1;
                    w_state            = RETURN;
                end
            end
            RETURN: begin
                if (bus.RES_ACK[r_grant]) begin
                    w_res_stb = '0;
                    w_rr_ptr  = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
                    w_state   = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_ab_stb  <= 1'b0;
            r_z_ack   <= 1'b0;
            r_res_z   <= '0;
            r_res_stb <= '0;
            r_req_ack <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_rr_ptr  <= w_rr_ptr;
            r_grant   <= w_grant;
            r_add_a   <= w_add_a;
            r_add_b   <= w_add_b;
            r_ab_stb  <= w_ab_stb;
            r_z_ack   <= w_z_ack;
            r_res_z   <= w_res_z;
            r_res_stb <= w_res_stb;
            r_req_ack <= w_req_ack;
            r_busy    <= w_busy;
        end
    end

    assign bus.REQ_ACK    = r_req_ack;
    assign bus.RES_Z      = r_res_z;
    assign bus.RES_STB    = r_res_stb;
    assign bus.ADD_A      = r_add_a;
    assign bus.ADD_B      = r_add_b;
    assign bus.ADD_AB_STB = r_ab_stb;
    assign bus.ADD_Z_ACK  = r_z_ack;
    assign o_BUSY         = r_busy;

endmodule : float_adder_arbiter
`default_nettype wire
